// File: rtl/ctrl_seq.sv
// Multi-cycle control sequencer for the 8-bit core: fetch, decode, execute, memory, write-back.
// Optional feature: define CTRL_TIMEOUT_EN for the imem/dmem ack timeout and err flag.
package ctrl_seq_pkg;
    localparam logic [4:0] kADD = 5'd0;
    localparam logic [4:0] kSUB = 5'd1;
    localparam logic [4:0] kAND = 5'd2;
    localparam logic [4:0] kXOR = 5'd3;
    localparam logic [4:0] kSLL = 5'd4;
    localparam logic [4:0] kSRL = 5'd5;
    localparam logic [4:0] kMOV = 5'd6;
    localparam logic [4:0] kCMP = 5'd7;
    localparam logic [4:0] kBE  = 5'd8;
    localparam logic [4:0] kBL  = 5'd9;
    localparam logic [4:0] kBG  = 5'd10;
    localparam logic [4:0] kBA  = 5'd11;
    localparam logic [4:0] kLD  = 5'd12;
    localparam logic [4:0] kST  = 5'd13;
    localparam logic [8:0] kHALT_WORD = 9'h1FF;
endpackage

module ctrl_seq
    import ctrl_seq_pkg::*;
#(
    parameter int PC_W = 8
`ifdef CTRL_TIMEOUT_EN
    , parameter int TIMEOUT = 255
`endif
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    output logic            imem_req,
    input  logic            imem_ack,
    input  logic [8:0]      imem_data,
    output logic [PC_W-1:0] pc,
    output logic [4:0]      alu_op,
    input  logic            alu_co,
    input  logic            alu_lt,
    input  logic            alu_z,
    output logic [1:0]      rf_raddr_a,
    output logic [1:0]      rf_raddr_b,
    output logic            rf_we,
    output logic [1:0]      rf_waddr,
    output logic            rf_wsel,
    output logic            dmem_req,
    output logic            dmem_we,
    input  logic            dmem_ack,
    output logic            busy,
    output logic            done,
    output logic            err
);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
    } state_t;

    state_t state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [8:0] instr_q, instr_d;
    logic co_q, co_d, lt_q, lt_d, z_q, z_d;
    logic imem_req_q, imem_req_d;
    logic dmem_req_q, dmem_req_d;
    logic dmem_we_q, dmem_we_d;
    logic rf_we_q, rf_we_d;
    logic rf_wsel_q, rf_wsel_d;
    logic busy_q, busy_d;
    logic done_q, done_d;
    logic [4:0] alu_op_q, alu_op_d;

`ifdef CTRL_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] wait_q, wait_d;
    logic err_q, err_d;
`endif

    logic [4:0] op, op_n;
    logic [PC_W-1:0] pc_inc, pc_br;

    assign op     = instr_q[8:4];
    assign op_n   = instr_d[8:4];
    assign pc_inc = pc_q + 1'b1;
    assign pc_br  = pc_q + {{(PC_W-4){instr_q[3]}}, instr_q[3:0]};

    function automatic logic is_wr(input logic [4:0] o);
        return (o == kADD) || (o == kSUB) || (o == kAND) || (o == kXOR) ||
               (o == kSLL) || (o == kSRL) || (o == kMOV);
    endfunction

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        co_d    = co_q;
        lt_d    = lt_q;
        z_d     = z_q;
`ifdef CTRL_TIMEOUT_EN
        err_d   = err_q;
        wait_d  = '0;
`endif
        unique case (state_q)
            S_IDLE, S_HALT: begin
                if (start) begin
                    state_d = S_FETCH;
                    pc_d    = '0;
`ifdef CTRL_TIMEOUT_EN
                    err_d   = 1'b0;
`endif
                end
            end
            S_FETCH: begin
                if (imem_ack) begin
                    instr_d = imem_data;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: state_d = S_EXEC;
            S_EXEC: begin
                state_d = S_FETCH;
                pc_d    = pc_inc;
                if (instr_q == kHALT_WORD) begin
                    state_d = S_HALT;
                    pc_d    = pc_q;
                end else begin
                    case (op)
                        kADD: co_d = alu_co;
                        kCMP: begin
                            z_d  = alu_z;
                            lt_d = alu_lt;
                        end
                        kBE: if (z_q) pc_d = pc_br;
                        kBL: if (lt_q) pc_d = pc_br;
                        kBG: if (!lt_q && !z_q) pc_d = pc_br;
                        kBA: pc_d = pc_br;
                        kLD, kST: begin
                            state_d = S_MEM;
                            pc_d    = pc_q;
                        end
                        default: ;
                    endcase
                end
            end
            S_MEM: begin
                if (dmem_ack) begin
                    if (op == kST) begin
                        state_d = S_FETCH;
                        pc_d    = pc_inc;
                    end else begin
                        state_d = S_WB;
                    end
                end
            end
            S_WB: begin
                state_d = S_FETCH;
                pc_d    = pc_inc;
            end
            default: state_d = S_IDLE;
        endcase
`ifdef CTRL_TIMEOUT_EN
        // Counter restarts on every state entry and on every ack.
        if ((state_q == S_FETCH && !imem_ack) ||
            (state_q == S_MEM && !dmem_ack)) begin
            if (wait_q == TW'(TIMEOUT - 1)) begin
                state_d = S_HALT;
                err_d   = 1'b1;
            end else begin
                wait_d = wait_q + 1'b1;
            end
        end
`endif
        // Outputs are registered, so derive them from the next state.
        imem_req_d = (state_d == S_FETCH);
        dmem_req_d = (state_d == S_MEM);
        dmem_we_d  = (state_d == S_MEM) && (op_n == kST);
        rf_we_d    = ((state_d == S_EXEC) && is_wr(op_n)) ||
                     (state_d == S_WB);
        rf_wsel_d  = (state_d == S_WB);
        alu_op_d   = (state_d == S_EXEC) ? op_n : kMOV;
        busy_d     = (state_d != S_IDLE) && (state_d != S_HALT);
        done_d     = (state_d == S_HALT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            pc_q       <= '0;
            instr_q    <= '0;
            co_q       <= 1'b0;
            lt_q       <= 1'b0;
            z_q        <= 1'b0;
            imem_req_q <= 1'b0;
            dmem_req_q <= 1'b0;
            dmem_we_q  <= 1'b0;
            rf_we_q    <= 1'b0;
            rf_wsel_q  <= 1'b0;
            alu_op_q   <= kMOV;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
`ifdef CTRL_TIMEOUT_EN
            wait_q     <= '0;
            err_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            co_q       <= co_d;
            lt_q       <= lt_d;
            z_q        <= z_d;
            imem_req_q <= imem_req_d;
            dmem_req_q <= dmem_req_d;
            dmem_we_q  <= dmem_we_d;
            rf_we_q    <= rf_we_d;
            rf_wsel_q  <= rf_wsel_d;
            alu_op_q   <= alu_op_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
`ifdef CTRL_TIMEOUT_EN
            wait_q     <= wait_d;
            err_q      <= err_d;
`endif
        end
    end

    assign imem_req   = imem_req_q;
    assign pc         = pc_q;
    assign alu_op     = alu_op_q;
    assign rf_raddr_a = instr_q[3:2];
    assign rf_raddr_b = instr_q[1:0];
    assign rf_waddr   = instr_q[3:2];
    assign rf_we      = rf_we_q;
    assign rf_wsel    = rf_wsel_q;
    assign dmem_req   = dmem_req_q;
    assign dmem_we    = dmem_we_q;
    assign busy       = busy_q;
    assign done       = done_q;
`ifdef CTRL_TIMEOUT_EN
    assign err        = err_q;
`else
    assign err        = 1'b0;
`endif

endmodule
